// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Time-shares one combinational 64-bit LEGv8 ALU between two requesters.
// A round-robin arbiter accepts one operation at a time, registers its
// operands toward the ALU, captures the result one cycle later, and holds
// it until the owning requester accepts it. Owns the NZCV (cpsr) register,
// which is loaded only by flag-setting operations.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester operation handshake
//   req{0,1}_a/_b [W-1:0]      operands, req{0,1}_ctrl [3:0] ALUControl
//   rsp_valid/rsp_ready [1:0]  per-requester result handshake
//   rsp_result [W-1:0]         captured result (shared bus)
//   rsp_zero                   captured zero flag
//   alu_a/alu_b/alu_ctrl       registered operands/control to the ALU
//   alu_result/alu_zero        ALU outputs
//   alu_write_flags/alu_flags  ALU flag-set strobe and flags {Z,N,C,V}
//   cpsr [3:0]                 architectural flags, same order as alu_flags
//   busy                       high in every state except IDLE
module alu_share_ctrl #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req0_ctrl,
  input  logic [3:0]   req1_ctrl,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_write_flags,
  input  logic [3:0]   alu_flags,
  output logic [3:0]   cpsr,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q;
  logic         prio_q;
  logic         owner_q;
  logic [W-1:0] alu_a_q;
  logic [W-1:0] alu_b_q;
  logic [3:0]   alu_ctrl_q;
  logic [W-1:0] rsp_result_q;
  logic         rsp_zero_q;
  logic [3:0]   cpsr_q;

  logic         gnt_any;
  logic         gnt_sel;

  // With both requesters valid the pointer decides; otherwise the single
  // valid requester wins. reset_n gates the grant so nothing is accepted
  // while reset is held.
  always_comb begin
    gnt_sel   = (req_valid == 2'b11) ? prio_q : req_valid[1];
    gnt_any   = reset_n && (state_q == IDLE) && (req_valid != 2'b00);
    req_ready = '0;
    if (gnt_any) begin
      req_ready = gnt_sel ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      cpsr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner_q    <= gnt_sel;
            prio_q     <= ~gnt_sel;
            alu_a_q    <= gnt_sel ? req1_a : req0_a;
            alu_b_q    <= gnt_sel ? req1_b : req0_b;
            alu_ctrl_q <= gnt_sel ? req1_ctrl : req0_ctrl;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          if (alu_write_flags) begin
            cpsr_q <= alu_flags;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign cpsr       = cpsr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-way arbiter that time-shares the single 64-bit LEGv8 ALU between two requesters (e.g. the main execute path and a branch/compare unit). Accepts one operation at a time through a valid/ready handshake and registers the operands toward the ALU. It captures the ALU result and owns the architectural NZCV (CPSR) flag register, updated only by flag-setting operations. It sits between the requesters and the combinational ALU, which is instantiated at the same hierarchy level.

## Interface
- `W`, default 64: operand/result width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester operation valid (bit i = requester i).
- `req_ready`  out  2  per-requester accept; one-hot or zero.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W  operands.
- `req0_ctrl`, `req1_ctrl`  in  4  ALUControl code.
- `rsp_valid`  out  2  per-requester result valid; one-hot or zero.
- `rsp_ready`  in  2  per-requester result accept.
- `rsp_result`  out  W  result (shared bus, meaningful for the bit set in `rsp_valid`).
- `rsp_zero`  out  1  zero flag of that result.
- `alu_a`, `alu_b`  out  W  registered operands to the ALU.
- `alu_ctrl`  out  4  registered ALUControl to the ALU.
- `alu_result`  in  W  ALU result.
- `alu_zero`  in  1  ALU zero.
- `alu_write_flags`  in  1  ALU flag-setting indication (ADDS 1010 / SUBS 1110).
- `alu_flags`  in  4  ALU flags: [3]=Z [2]=N [1]=C [0]=V.
- `cpsr`  out  4  architectural NZCV register, same bit order as `alu_flags`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If `req_valid` is nonzero, grant one requester combinationally: `req_ready[g]`=1 for exactly that cycle.
  - Latch `reqg_a`/`reqg_b`/`reqg_ctrl` into the `alu_a`/`alu_b`/`alu_ctrl` registers and record owner g; go to EXEC.
  - Otherwise stay in IDLE; `req_ready` is 0.
- **Arbitration**
  - Round-robin pointer `prio`; reset value 0.
  - Only one requester valid: that requester is granted.
  - Both valid: grant `prio`; after the grant, `prio` becomes the other requester.
  - `prio` changes only on a grant.
- **EXEC**
  - ALU is combinational on the registered inputs.
  - Capture `alu_result` and `alu_zero` into response registers.
  - If `alu_write_flags`=1, load `cpsr` from `alu_flags`; otherwise `cpsr` holds its value. It is not cleared.
  - Go to RESP.
- **RESP**
  - `rsp_valid[owner]`=1; `rsp_result` and `rsp_zero` hold the captured values.
  - When `rsp_ready[owner]`=1, return to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `req_ready` is 0 outside IDLE. Requesters hold `req_valid` and their operands until accepted.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last value outside the grant cycle.
- Control codes are passed through unchecked. An unsupported code yields result 0 and zero=1 from the ALU, and `cpsr` is unchanged.
- Width: operands and result are W bits with no extension. Flags come solely from the ALU.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - State IDLE, `prio`=0.
  - `alu_a`=`alu_b`=0, `alu_ctrl`=0.
  - `rsp_result`=0, `rsp_zero`=0, `rsp_valid`=0, `cpsr`=0, `busy`=0.
  - `req_ready`=0 while in reset.
- Latency: accept at edge T (valid & ready); `alu_*` valid after T; `cpsr` updated at T+1; `rsp_valid` high from after T+1.
- Back-to-back throughput: one operation per 3 cycles when `rsp_ready` is held high.
- Reset asserted mid-operation: the in-flight operation is dropped with no response, `cpsr` returns to 0, and the requester must re-issue.
- `rsp_ready` high before `rsp_valid` has no effect.

## Test plan
- **Reset:** `reset_n`=0 during RESP -> `rsp_valid`=0, `cpsr`=0, `busy`=0 immediately; after release, the first grant goes to requester 0 when both are valid.
- **Single ADD:** req0 a=5, b=7, ctrl=0010 -> `req_ready`=01 for one cycle, `rsp_valid`=01 two cycles later, `rsp_result`=12, `cpsr` unchanged.
- **SUBS equal:** req1 a=9, b=9, ctrl=1110 -> result 0, `rsp_zero`=1, `cpsr`[3]=1 (Z); a following ORR (0001) leaves `cpsr` unchanged.
- **Contention:** both valid continuously with `rsp_ready`=11 -> grants alternate 0,1,0,1, one every 3 cycles.
- **Backpressure:** req0 ADD with `rsp_ready`=0 for 5 cycles -> `rsp_valid`=01 and `rsp_result` held stable, `req_ready`=00, req1 not granted; release -> IDLE next cycle, then req1 granted.
- **ADDS overflow:** a=0x7FFF…F, b=1, ctrl=1010 -> result 0x8000…0, `cpsr` equals the ALU flags of that operation.
